broadcast_stream: RTL

Expansion counterpart of the tree reduction stage in the attention datapath. Accepts one list of reduced values per handshake, such as row sums or row maxima. Replicates each element 2^STEPS times back to full embedding length and streams the expanded vector downstream in CHUNK_LEN-element beats. Sits between the reduction/normalisation logic and the elementwise PE array that consumes per-element scale factors.

---
 rtl/broadcast_stream.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/broadcast_stream.sv
// broadcast_stream: takes one reduced list per handshake (for example row sums
// or row maxima), replicates each element 2^STEPS times back to the full
// embedding length, and streams the result downstream in CHUNK_LEN-element beats.
//
// Optional feature macro: BROADCAST_SAT_EN
//   This macro only matters when W_OUT < W_IN.
//   Defined:   each element is clamped to the W_OUT signed range, and sat_out
//              flags every beat in which at least one lane was clamped.
//   Undefined: the low W_OUT bits are kept (two's-complement wrap), and
//              sat_out is tied to 0.
//
// State | meaning
// IDLE  | no vector held; ready for list_in
// SEND  | presenting beat beat_q of the held vector

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 8
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 4
`endif

module broadcast_stream #(
  parameter int STEPS      = 1,
  parameter int INPUT_LEN  = `MAX_EMBEDDING_DIM >> STEPS,
  parameter int OUTPUT_LEN = INPUT_LEN << STEPS,
  parameter int CHUNK_LEN  = OUTPUT_LEN >> 1,
  parameter int W_IN       = 2 * `INTEGER_WIDTH + STEPS,
  parameter int W_OUT      = 2 * `INTEGER_WIDTH,
  localparam int BEATS     = OUTPUT_LEN / CHUNK_LEN,
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            vld_in,
  output logic                            rdy_out,
  input  logic [INPUT_LEN-1:0][W_IN-1:0]  list_in,
  output logic                            vld_out,
  input  logic                            rdy_in,
  output logic [CHUNK_LEN-1:0][W_OUT-1:0] list_out,
  output logic [BW-1:0]                   beat_idx,
  output logic                            last_out,
  output logic                            sat_out
);

  localparam int IW = (INPUT_LEN > 1) ? $clog2(INPUT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic SINGLE_BEAT = (BEATS == 1);

  // Clamp bounds of the output element range, kept as int so that the
  // comparison does not depend on how W_IN relates to W_OUT.
  localparam int SAT_HI = (1 << (W_OUT - 1)) - 1;
  localparam int SAT_LO = -(1 << (W_OUT - 1));
`ifdef BROADCAST_SAT_EN
  localparam bit SAT_ACTIVE = (W_OUT < W_IN);
`else
  localparam bit SAT_ACTIVE = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state_q;
  logic [INPUT_LEN-1:0][W_IN-1:0] vec_q;
  logic [BW-1:0]                  beat_q;
  logic [BW-1:0]                  beat_d;
  logic                           vld_q;
  logic                           last_q;
  logic                           beat_at_last;

  logic [IW-1:0]                  idx;
  logic signed [W_IN-1:0]         elem;

  assign beat_at_last = (beat_q == LAST_BEAT);
  assign beat_d       = beat_q + BW'(1);

  // Ready in IDLE, or when the final beat is leaving so that the next vector
  // follows with no bubble. This is a combinational path from rdy_in.
  always_comb begin
    rdy_out = (state_q == IDLE) || ((state_q == SEND) && rdy_in && beat_at_last);
  end

  // Control FSM: it holds the vector and the beat position and drives the
  // registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      beat_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vld_in) begin
            vec_q   <= list_in;
            beat_q  <= '0;
            vld_q   <= 1'b1;
            last_q  <= SINGLE_BEAT;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (rdy_in) begin
            if (!beat_at_last) begin
              beat_q <= beat_d;
              last_q <= (beat_d == LAST_BEAT);
            end else if (vld_in) begin
              vec_q  <= list_in;
              beat_q <= '0;
              last_q <= SINGLE_BEAT;
            end else begin
              vld_q   <= 1'b0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat datapath: lane j of beat b carries expanded element b*CHUNK_LEN+j,
  // which is source element (b*CHUNK_LEN+j) >> STEPS, converted to W_OUT bits.
  always_comb begin
    list_out = '0;
    sat_out  = 1'b0;
    idx      = '0;
    elem     = '0;
    for (int j = 0; j < CHUNK_LEN; j++) begin
      idx  = IW'((int'(beat_q) * CHUNK_LEN + j) >> STEPS);
      elem = vec_q[idx];
      if (SAT_ACTIVE && (int'(elem) > SAT_HI)) begin
        list_out[j] = W_OUT'(SAT_HI);
        sat_out     = 1'b1;
      end else if (SAT_ACTIVE && (int'(elem) < SAT_LO)) begin
        list_out[j] = W_OUT'(SAT_LO);
        sat_out     = 1'b1;
      end else begin
        // The size cast sign-extends when widening and wraps when narrowing.
        list_out[j] = W_OUT'(elem);
      end
    end
  end

  assign vld_out  = vld_q;
  assign beat_idx = beat_q;
  assign last_out = last_q;

endmodule
